mem_access_unit: RTL and testbench

MEM stage of the 5-stage MIPS pipeline. It consumes the execute-stage results: ALU result/address, store data, read/write strobes, byte flag and destination register.
- Memory ops (LW, LB, SW, SB): runs a multi-cycle access on the external asynchronous SRAM, extracts and sign-extends bytes, and stalls the upstream pipeline while busy.
- Non-memory ops: passes through to the write-back stage in one cycle.

---
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS MEM stage driving an async SRAM with multi-cycle strobes; stalls upstream while busy.
// Optional SRAM_RMW_EN: SB becomes a read-modify-write for SRAMs without byte enables.
module mem_access_unit #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       result_i,
    input  logic [31:0]       mem_data_i,
    input  logic              load_byte_i,
    input  logic              if_mem_read_i,
    input  logic              if_mem_write_i,
    input  logic              if_reg_write_i,
    input  logic [4:0]        data_write_reg_i,
    output logic              mem_stall_o,
    output logic [31:0]       wb_data_o,
    output logic              wb_reg_write_o,
    output logic [4:0]        wb_reg_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    output logic              sram_wdata_oe_o,
    input  logic [31:0]       sram_rdata_i,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o
);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        lane_q, lane_d;
    logic              byte_q, byte_d;
    logic              regw_q, regw_d;
    logic              rmw_q, rmw_d;
    logic              was_wr_q;
    logic [4:0]        dest_q, dest_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              wb_regw_q, wb_regw_d;
    logic [4:0]        wb_reg_q, wb_reg_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        rbyte;
    logic [31:0]       merged;
    logic              req, last, rmw_req;

    assign req   = if_mem_read_i | if_mem_write_i;
    assign last  = cnt_q == '0;
    assign rbyte = sram_rdata_i[{lane_q, 3'b000} +: 8];

`ifdef SRAM_RMW_EN
    assign rmw_req = if_mem_write_i & ~if_mem_read_i & load_byte_i;
`else
    assign rmw_req = 1'b0;
`endif

    // Byte-store merge into the word captured during the read phase of a read-modify-write
    always_comb begin
        merged = sram_rdata_i;
        merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lane_d    = lane_q;
        byte_d    = byte_q;
        regw_d    = regw_q;
        rmw_d     = rmw_q;
        dest_d    = dest_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        wb_data_d = wb_data_q;
        wb_regw_d = wb_regw_q;
        wb_reg_d  = wb_reg_q;
        addr_d    = addr_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d    = result_i[ADDR_W+1:2];
                    lane_d    = result_i[1:0];
                    byte_d    = load_byte_i;
                    regw_d    = if_reg_write_i;
                    dest_d    = data_write_reg_i;
                    rmw_d     = rmw_req;
                    wdata_d   = load_byte_i ? {4{mem_data_i[7:0]}} : mem_data_i;
                    be_d      = (load_byte_i && !rmw_req) ? ~(4'b0001 << result_i[1:0]) : 4'h0;
                    wb_regw_d = 1'b0;
                    cnt_d     = CW'(WAIT_STATES);
                    state_d   = (if_mem_read_i || rmw_req) ? RD : WR;
                end else begin
                    wb_data_d = result_i;
                    wb_regw_d = if_reg_write_i;
                    wb_reg_d  = data_write_reg_i;
                end
            end
            RD: begin
                cnt_d = cnt_q - 1'b1;
                if (last && rmw_q) begin
                    wdata_d = merged;
                    cnt_d   = CW'(WAIT_STATES);
                    state_d = WR;
                end else if (last) begin
                    wb_data_d = byte_q ? {{24{rbyte[7]}}, rbyte} : sram_rdata_i;
                    wb_regw_d = regw_q;
                    wb_reg_d  = dest_q;
                    state_d   = DONE;
                end
            end
            WR: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = last ? DONE : WR;
            end
            DONE: begin
                wb_regw_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lane_q    <= '0;
            byte_q    <= 1'b0;
            regw_q    <= 1'b0;
            rmw_q     <= 1'b0;
            was_wr_q  <= 1'b0;
            dest_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            wb_data_q <= '0;
            wb_regw_q <= 1'b0;
            wb_reg_q  <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lane_q    <= lane_d;
            byte_q    <= byte_d;
            regw_q    <= regw_d;
            rmw_q     <= rmw_d;
            was_wr_q  <= state_q == WR;
            dest_q    <= dest_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            wb_data_q <= wb_data_d;
            wb_regw_q <= wb_regw_d;
            wb_reg_q  <= wb_reg_d;
            addr_q    <= addr_d;
        end
    end

    // Strobes decode from the state register only, so reset drops them immediately
    assign mem_stall_o     = rst_n & (((state_q == IDLE) & req) | (state_q == RD) | (state_q == WR));
    assign sram_ce_n_o     = !((state_q == RD) || (state_q == WR));
    assign sram_oe_n_o     = state_q != RD;
    assign sram_we_n_o     = state_q != WR;
    assign sram_be_n_o     = (state_q == RD) ? 4'h0 : (state_q == WR) ? be_q : 4'hF;
    assign sram_wdata_oe_o = (state_q == WR) || ((state_q == DONE) && was_wr_q);
    assign sram_wdata_o    = wdata_q;
    assign sram_addr_o     = addr_q;
    assign wb_data_o       = wb_data_q;
    assign wb_reg_write_o  = wb_regw_q;
    assign wb_reg_o        = wb_reg_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized bench for mem_access_unit; a golden word memory and spec-level arithmetic give all expectations.
`timescale 1ns/1ps
module tb_mem_access_unit;
    localparam int ADDR_W = 20;
    localparam int WS     = 1;
`ifdef SRAM_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif
    localparam int K_ALU = 0, K_LW = 1, K_LB = 2, K_SW = 3, K_SB = 4, K_BOTH = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       result = '0, mem_data = '0;
    logic              load_byte = 1'b0, mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0;
    logic [4:0]        dest = '0;
    logic              stall, wb_regw, s_oe, ce_n, oe_n, we_n;
    logic [31:0]       wb_data, s_wdata, s_rdata;
    logic [4:0]        wb_reg;
    logic [ADDR_W-1:0] s_addr;
    logic [3:0]        be_n;

    logic [31:0] sram [0:255];
    logic [31:0] gm   [0:255];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_a = '0;
    logic [31:0] bd_d = '0;
    logic [31:0] bm;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n), .result_i(result), .mem_data_i(mem_data),
        .load_byte_i(load_byte), .if_mem_read_i(mem_read), .if_mem_write_i(mem_write),
        .if_reg_write_i(reg_write), .data_write_reg_i(dest), .mem_stall_o(stall),
        .wb_data_o(wb_data), .wb_reg_write_o(wb_regw), .wb_reg_o(wb_reg),
        .sram_addr_o(s_addr), .sram_wdata_o(s_wdata), .sram_wdata_oe_o(s_oe),
        .sram_rdata_i(s_rdata), .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n),
        .sram_we_n_o(we_n), .sram_be_n_o(be_n)
    );

    // Asynchronous SRAM model with active-low byte lanes
    assign s_rdata = (!ce_n && !oe_n) ? sram[s_addr[7:0]] : 32'h0BADF00D;
    assign bm = {{8{!be_n[3]}}, {8{!be_n[2]}}, {8{!be_n[1]}}, {8{!be_n[0]}}};
    always @(posedge clk) begin
        if (bd_we) sram[bd_a] <= bd_d;
        else if (!ce_n && !we_n) sram[s_addr[7:0]] <= (sram[s_addr[7:0]] & ~bm) | (s_wdata & bm);
    end

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_a = a; bd_d = d; gm[a] = d;
        @(posedge clk); #2;
        bd_we = 1'b0;
    endtask

    task automatic drive(input int kind, input logic [31:0] res, input logic [31:0] data,
                         input logic [4:0] dst, input logic regw);
        result = res; mem_data = data; dest = dst; reg_write = regw;
        mem_read  = kind == K_LW || kind == K_LB || kind == K_BOTH;
        mem_write = kind == K_SW || kind == K_SB || kind == K_BOTH;
        load_byte = kind == K_LB || kind == K_SB;
    endtask

    task automatic issue(input int kind, input logic [31:0] res, input logic [31:0] data,
                         input logic [4:0] dst, input logic regw);
        bit rd, wr;
        logic [7:0] wa, b8;
        int lane, st_exp, oe_exp, we_exp;
        int st = 0, oec = 0, wec = 0, bad = 0, clash = 0, n = 0;
        logic [31:0] exp_d, exp_wd, wdat = '0;
        logic [3:0] exp_be, wbe = 4'hF;
        logic [ADDR_W-1:0] a_seen = '0;
        rd = kind == K_LW || kind == K_LB || kind == K_BOTH;
        wr = kind == K_SW || kind == K_SB;
        wa = res[9:2];
        lane = int'(res[1:0]);
        b8 = 8'(gm[wa] >> (8 * lane));
        exp_d = (kind == K_LB) ? ((b8 >= 8'd128) ? 32'(b8) - 32'd256 : 32'(b8)) : gm[wa];
        if (kind == K_SB) gm[wa] = (gm[wa] & ~(32'hFF << (8 * lane))) | (32'(data[7:0]) << (8 * lane));
        else if (kind == K_SW) gm[wa] = data;
        exp_wd = (kind == K_SB && !RMW) ? 32'(data[7:0]) * 32'h01010101 : gm[wa];
        exp_be = (kind == K_SB && !RMW) ? 4'hF ^ 4'(1 << lane) : 4'h0;
        st_exp = (kind == K_ALU) ? 0 : (kind == K_SB && RMW) ? 2 * WS + 3 : WS + 2;
        oe_exp = (rd || (kind == K_SB && RMW)) ? WS + 1 : 0;
        we_exp = wr ? WS + 1 : 0;
        drive(kind, res, data, dst, regw);
        #1;
        while (stall && n < 50) begin
            st++;
            if (!oe_n) oec++;
            if (!we_n) begin wec++; wbe = be_n; wdat = s_wdata; end
            if (!oe_n || !we_n) a_seen = s_addr;
            if (n > 0 && wb_regw) bad++;
            if (!oe_n && s_oe) clash++;
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (st != st_exp) begin errors++; $display("FAIL stall_cycles kind=%0d res=%h: got %0d want %0d", kind, res, st, st_exp); end
        if (kind == K_ALU) begin
            @(posedge clk); #2;
            checks++;
            if (wb_data !== res || wb_regw !== regw || wb_reg !== dst) begin
                errors++;
                $display("FAIL alu_pass res=%h: got data=%h we=%b reg=%0d want data=%h we=%b reg=%0d", res, wb_data, wb_regw, wb_reg, res, regw, dst);
            end
            return;
        end
        checks++;
        if (oec != oe_exp || wec != we_exp) begin
            errors++; $display("FAIL strobe_cycles kind=%0d res=%h: got oe=%0d we=%0d want oe=%0d we=%0d", kind, res, oec, wec, oe_exp, we_exp);
        end
        checks++;
        if (a_seen !== ADDR_W'(wa)) begin errors++; $display("FAIL sram_addr res=%h: got %h want %h", res, a_seen, wa); end
        checks++;
        if (bad != 0 || clash != 0) begin errors++; $display("FAIL busy_hazard kind=%0d res=%h: got wb_we_cycles=%0d bus_clash=%0d want 0 0", kind, res, bad, clash); end
        if (rd) begin
            checks++;
            if (wb_data !== exp_d || wb_regw !== regw || wb_reg !== dst) begin
                errors++;
                $display("FAIL load_wb kind=%0d res=%h: got data=%h we=%b reg=%0d want data=%h we=%b reg=%0d", kind, res, wb_data, wb_regw, wb_reg, exp_d, regw, dst);
            end
        end
        if (wr) begin
            checks++;
            if (wb_regw !== 1'b0 || s_oe !== 1'b1) begin errors++; $display("FAIL store_done res=%h: got we=%b oe=%b want we=0 oe=1", res, wb_regw, s_oe); end
            checks++;
            if (wbe !== exp_be || wdat !== exp_wd) begin
                errors++; $display("FAIL store_bus kind=%0d res=%h: got be_n=%b wdata=%h want be_n=%b wdata=%h", kind, res, wbe, wdat, exp_be, exp_wd);
            end
        end
        drive(K_ALU, 32'h0, 32'h0, 5'd0, 1'b0);
        @(posedge clk); #2;
        checks++;
        if (wb_regw !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL after_done res=%h: got we=%b stall=%b want 0 0", res, wb_regw, stall); end
        checks++;
        if (sram[wa] !== gm[wa]) begin errors++; $display("FAIL sram_content word=%h: got %h want %h", wa, sram[wa], gm[wa]); end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
        checks++;
        if (wb_data !== '0 || wb_regw !== 1'b0 || wb_reg !== '0 || s_addr !== '0 || s_wdata !== '0 || s_oe !== 1'b0) begin
            errors++; $display("FAIL reset_regs: got wb=%h we=%b reg=%0d addr=%h wd=%h oe=%b want all 0", wb_data, wb_regw, wb_reg, s_addr, s_wdata, s_oe);
        end
        checks++;
        if (ce_n !== 1'b1 || oe_n !== 1'b1 || we_n !== 1'b1 || be_n !== 4'hF || stall !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: got ce=%b oe=%b we=%b be=%b stall=%b want 1 1 1 1111 0", ce_n, oe_n, we_n, be_n, stall);
        end
        rst_n = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_alu();
        issue(K_ALU, 32'h1234, 32'h0, 5'd5, 1'b1);
        issue(K_ALU, 32'hFEDC_BA98, 32'h0, 5'd31, 1'b0);
    endtask

    task automatic test_lw();
        poke(8'h40, 32'hDEADBEEF);
        issue(K_LW, 32'h100, 32'h0, 5'd8, 1'b1);
        issue(K_LW, 32'h102, 32'h0, 5'd9, 1'b1);
    endtask

    task automatic test_lb();
        poke(8'h40, 32'h80000000);
        issue(K_LB, 32'h103, 32'h0, 5'd10, 1'b1);
        poke(8'h40, 32'h7F000000);
        issue(K_LB, 32'h103, 32'h0, 5'd11, 1'b1);
    endtask

    task automatic test_sb();
        poke(8'h80, 32'h11223344);
        issue(K_SB, 32'h202, 32'h000000A5, 5'd3, 1'b0);
        issue(K_SB, 32'h204, 32'h0000005A, 5'd4, 1'b1);
    endtask

    task automatic test_priority();
        issue(K_BOTH, 32'h104, 32'h55AA55AA, 5'd12, 1'b1);
    endtask

    task automatic test_back_to_back();
        issue(K_SW, 32'h300, $urandom, 5'd0, 1'b0);
        issue(K_LW, 32'h300, 32'h0, 5'd13, 1'b1);
        issue(K_SB, 32'h301, $urandom, 5'd0, 1'b0);
        issue(K_LB, 32'h301, 32'h0, 5'd14, 1'b1);
    endtask

    task automatic test_reset_mid();
        poke(8'h40, 32'hCAFEF00D);
        drive(K_LW, 32'h100, 32'h0, 5'd6, 1'b1);
        @(posedge clk); #2;
        checks++;
        if (oe_n !== 1'b0) begin errors++; $display("FAIL rd_entered: got oe_n=%b want 0", oe_n); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ce_n !== 1'b1 || oe_n !== 1'b1 || we_n !== 1'b1 || be_n !== 4'hF || wb_regw !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL async_reset: got ce=%b oe=%b we=%b be=%b we_wb=%b stall=%b want 1 1 1 1111 0 0", ce_n, oe_n, we_n, be_n, wb_regw, stall);
        end
        drive(K_ALU, 32'h0, 32'h0, 5'd0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        issue(K_LW, 32'h100, 32'h0, 5'd7, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int k;
            logic [31:0] r;
            k = $urandom_range(0, 5);
            r = (k == K_ALU) ? $urandom : 32'($urandom_range(0, 1023));
            issue(k, r, $urandom, 5'($urandom_range(0, 31)), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lw();
        test_lb();
        test_sb();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
